// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed driver for a six-digit common-cathode
//               seven-segment display. Six hex nibbles, decimal points and
//               per-digit enables are captured into a shadow set on `load`
//               and copied to the displayed (active) set only at a frame
//               boundary, so one frame never mixes old and new data. Each
//               digit slot lasts DIV cycles and starts with BLANK cycles
//               of all-off output to suppress ghosting between digits.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIV          clock cycles per digit slot (4 .. 65535)
//   BLANK        blank cycles at the start of each slot (1 .. DIV-2)
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   data_in      six hex nibbles; digit i is data_in[4i+3:4i]
//   dp_in        decimal point per digit, 1 = lit
//   en_in        digit enable, 1 = shown
//   load         one-cycle strobe capturing data_in/dp_in/en_in
//   pending      shadow data waiting for the next frame boundary
//   frame_start  one-cycle pulse when slot 0 begins
//   digit_cath   digit select, active-low, bit i selects digit i
//   seg          segments, active-high, seg[0..6] = a..g, seg[7] = dp
// ============================================================================
module seg_scan_driver #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_in,
    input  logic [5:0]  dp_in,
    input  logic [5:0]  en_in,
    input  logic        load,
    output logic        pending,
    output logic        frame_start,
    output logic [5:0]  digit_cath,
    output logic [7:0]  seg
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_CNT_LAST  = 16'(DIV - 1);
    localparam logic [15:0] c_BLANK_END = 16'(BLANK);
    localparam logic [2:0]  c_SLOT_LAST = 3'd5;
    localparam logic [5:0]  c_CATH_OFF  = 6'b111111;
    localparam logic [7:0]  c_SEG_OFF   = 8'h00;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [15:0] r_cnt;
    logic [2:0]  r_slot;

    logic [23:0] r_shd_data;
    logic [5:0]  r_shd_dp;
    logic [5:0]  r_shd_en;

    logic [23:0] r_act_data;
    logic [5:0]  r_act_dp;
    logic [5:0]  r_act_en;

    logic        r_pending;
    logic        r_frame_start;
    logic [5:0]  r_digit_cath;
    logic [7:0]  r_seg;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_slot_end;
    logic        w_boundary;
    logic        w_drive;
    logic        w_slot_first;
    logic [3:0]  w_nibble;
    logic        w_dp_bit;
    logic        w_en_bit;
    logic [5:0]  w_cath_sel;
    logic [6:0]  w_hex_seg;
    logic [5:0]  w_next_cath;
    logic [7:0]  w_next_seg;

    assign w_slot_end   = (r_cnt == c_CNT_LAST);
    assign w_boundary   = w_slot_end && (r_slot == c_SLOT_LAST);
    assign w_drive      = (r_cnt >= c_BLANK_END);
    assign w_slot_first = (r_cnt == 16'd0) && (r_slot == 3'd0);

    // Select the active digit's nibble, dp, enable and cathode pattern.
    // Slot codes 6 and 7 never occur; they map to an all-off digit.
    always_comb begin
        w_nibble   = 4'h0;
        w_dp_bit   = 1'b0;
        w_en_bit   = 1'b0;
        w_cath_sel = c_CATH_OFF;
        case (r_slot)
            3'd0: begin
                w_nibble   = r_act_data[3:0];
                w_dp_bit   = r_act_dp[0];
                w_en_bit   = r_act_en[0];
                w_cath_sel = 6'b111110;
            end
            3'd1: begin
                w_nibble   = r_act_data[7:4];
                w_dp_bit   = r_act_dp[1];
                w_en_bit   = r_act_en[1];
                w_cath_sel = 6'b111101;
            end
            3'd2: begin
                w_nibble   = r_act_data[11:8];
                w_dp_bit   = r_act_dp[2];
                w_en_bit   = r_act_en[2];
                w_cath_sel = 6'b111011;
            end
            3'd3: begin
                w_nibble   = r_act_data[15:12];
                w_dp_bit   = r_act_dp[3];
                w_en_bit   = r_act_en[3];
                w_cath_sel = 6'b110111;
            end
            3'd4: begin
                w_nibble   = r_act_data[19:16];
                w_dp_bit   = r_act_dp[4];
                w_en_bit   = r_act_en[4];
                w_cath_sel = 6'b101111;
            end
            3'd5: begin
                w_nibble   = r_act_data[23:20];
                w_dp_bit   = r_act_dp[5];
                w_en_bit   = r_act_en[5];
                w_cath_sel = 6'b011111;
            end
            default: begin
                w_nibble   = 4'h0;
                w_dp_bit   = 1'b0;
                w_en_bit   = 1'b0;
                w_cath_sel = c_CATH_OFF;
            end
        endcase
    end

    // Hex to segment decode, bit 0 = a ... bit 6 = g.
    always_comb begin
        w_hex_seg = 7'h00;
        case (w_nibble)
            4'h0: w_hex_seg = 7'h3F;
            4'h1: w_hex_seg = 7'h06;
            4'h2: w_hex_seg = 7'h5B;
            4'h3: w_hex_seg = 7'h4F;
            4'h4: w_hex_seg = 7'h66;
            4'h5: w_hex_seg = 7'h6D;
            4'h6: w_hex_seg = 7'h7D;
            4'h7: w_hex_seg = 7'h07;
            4'h8: w_hex_seg = 7'h7F;
            4'h9: w_hex_seg = 7'h6F;
            4'hA: w_hex_seg = 7'h77;
            4'hB: w_hex_seg = 7'h7C;
            4'hC: w_hex_seg = 7'h39;
            4'hD: w_hex_seg = 7'h5E;
            4'hE: w_hex_seg = 7'h79;
            4'hF: w_hex_seg = 7'h71;
            default: w_hex_seg = 7'h00;
        endcase
    end

    // A disabled digit still owns its slot; it simply stays dark so the
    // scan period does not depend on the enable pattern.
    always_comb begin
        w_next_cath = c_CATH_OFF;
        w_next_seg  = c_SEG_OFF;
        if (w_drive && w_en_bit) begin
            w_next_cath = w_cath_sel;
            w_next_seg  = {w_dp_bit, w_hex_seg};
        end
    end

    // ------------------------------------------------------------------------
    // Slot timer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 16'd0;
            r_slot <= 3'd0;
        end else if (w_slot_end) begin
            r_cnt  <= 16'd0;
            r_slot <= (r_slot == c_SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
        end else begin
            r_cnt  <= r_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow / active data sets
    // The load branch is written last so that its pending set overrides the
    // boundary clear. On a coincident load the boundary still moves the old
    // shadow to active, while the new inputs land in shadow for next frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shd_data <= 24'd0;
            r_shd_dp   <= 6'd0;
            r_shd_en   <= 6'd0;
            r_act_data <= 24'd0;
            r_act_dp   <= 6'd0;
            r_act_en   <= 6'd0;
            r_pending  <= 1'b0;
        end else begin
            if (w_boundary) begin
                if (r_pending) begin
                    r_act_data <= r_shd_data;
                    r_act_dp   <= r_shd_dp;
                    r_act_en   <= r_shd_en;
                end
                r_pending <= 1'b0;
            end
            if (load) begin
                r_shd_data <= data_in;
                r_shd_dp   <= dp_in;
                r_shd_en   <= en_in;
                r_pending  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers. Because every slot begins with at least one blank
    // cycle, the cathode register always passes through all-off between two
    // digits and never shows two selected digits at once.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_start <= 1'b0;
            r_digit_cath  <= c_CATH_OFF;
            r_seg         <= c_SEG_OFF;
        end else begin
            r_frame_start <= w_slot_first;
            r_digit_cath  <= w_next_cath;
            r_seg         <= w_next_seg;
        end
    end

    assign pending     = r_pending;
    assign frame_start = r_frame_start;
    assign digit_cath  = r_digit_cath;
    assign seg         = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Directed, table-driven bench for seg_scan_driver with
//               DIV=8, BLANK=2 (48-cycle frame). Cycle 0 is the first cycle
//               with rst low; inputs change 1 time unit after a rising edge
//               and outputs are sampled at the same point.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int c_DIV   = 8;
    localparam int c_BLANK = 2;
    localparam int c_FRAME = 6 * c_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data_in = 24'd0;
    logic [5:0]  dp_in = 6'd0;
    logic [5:0]  en_in = 6'd0;
    logic        load = 1'b0;
    logic        pending;
    logic        frame_start;
    logic [5:0]  digit_cath;
    logic [7:0]  seg;

    seg_scan_driver #(
        .DIV   (c_DIV),
        .BLANK (c_BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .load        (load),
        .pending     (pending),
        .frame_start (frame_start),
        .digit_cath  (digit_cath),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] data;
        logic [5:0]  dp;
        logic [5:0]  en;
    } load_t;

    typedef struct {
        int          cyc;
        logic [5:0]  cath;
        logic [7:0]  seg;
        logic        pend;
        logic        fs;
    } vec_t;

    load_t loads[$];
    vec_t  vecs[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_tables();
        loads.delete();
        vecs.delete();
    endtask

    task automatic add_load(input int c, input logic [23:0] d, input logic [5:0] dp,
                            input logic [5:0] en);
        load_t r;
        r.cyc = c; r.data = d; r.dp = dp; r.en = en;
        loads.push_back(r);
    endtask

    task automatic add_vec(input int c, input logic [5:0] cath, input logic [7:0] sg,
                           input logic pend, input logic fs);
        vec_t v;
        v.cyc = c; v.cath = cath; v.seg = sg; v.pend = pend; v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
    endtask

    // Runs ncyc cycles starting at cycle 0 (caller is 1 unit after the edge
    // that begins cycle 0). Applies the load table, compares the vector table,
    // and tracks per-cycle invariants.
    task automatic run(input string tag, input int ncyc, input bit all_blank,
                       input bit even_blank);
        int onehot_bad = 0;
        int fs_bad     = 0;
        int blank_bad  = 0;
        for (int c = 0; c < ncyc; c++) begin
            load = 1'b0;
            foreach (loads[i]) begin
                if (loads[i].cyc == c) begin
                    load    = 1'b1;
                    data_in = loads[i].data;
                    dp_in   = loads[i].dp;
                    en_in   = loads[i].en;
                end
            end
            if ($countones(~digit_cath) > 1) onehot_bad++;
            if (frame_start !== ((c % c_FRAME) == 1)) fs_bad++;
            if (all_blank && (digit_cath !== 6'h3F || seg !== 8'h00)) blank_bad++;
            if (even_blank && c >= 1 && (((((c - 1) % c_FRAME) / c_DIV) % 2) == 0) &&
                (digit_cath !== 6'h3F || seg !== 8'h00)) blank_bad++;
            foreach (vecs[i]) begin
                if (vecs[i].cyc == c) begin
                    check($sformatf("%s c%0d digit_cath", tag, c), 32'(digit_cath), 32'(vecs[i].cath));
                    check($sformatf("%s c%0d seg", tag, c), 32'(seg), 32'(vecs[i].seg));
                    check($sformatf("%s c%0d pending", tag, c), 32'(pending), 32'(vecs[i].pend));
                    check($sformatf("%s c%0d frame_start", tag, c), 32'(frame_start), 32'(vecs[i].fs));
                end
            end
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        check({tag, " cathode_onehot_violations"}, 32'(onehot_bad), 32'd0);
        check({tag, " frame_start_timing_errors"}, 32'(fs_bad), 32'd0);
        if (all_blank || even_blank)
            check({tag, " blank_violations"}, 32'(blank_bad), 32'd0);
    endtask

    initial begin
        // ---------------- reset and blank ----------------
        clear_tables();
        add_vec(0,  6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(1,  6'h3F, 8'h00, 1'b0, 1'b1);
        add_vec(48, 6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(49, 6'h3F, 8'h00, 1'b0, 1'b1);
        add_vec(97, 6'h3F, 8'h00, 1'b0, 1'b1);
        do_reset();
        run("reset_blank", 100, 1'b1, 1'b0);

        // ---------------- scan order and decode ----------------
        clear_tables();
        add_load(5, 24'h543210, 6'b000001, 6'h3F);
        add_vec(5,  6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(6,  6'h3F, 8'h00, 1'b1, 1'b0);
        add_vec(11, 6'h3F, 8'h00, 1'b1, 1'b0);
        add_vec(47, 6'h3F, 8'h00, 1'b1, 1'b0);
        add_vec(48, 6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(50, 6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(51, 6'h3E, 8'hBF, 1'b0, 1'b0);
        add_vec(56, 6'h3E, 8'hBF, 1'b0, 1'b0);
        add_vec(57, 6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(59, 6'h3D, 8'h06, 1'b0, 1'b0);
        add_vec(67, 6'h3B, 8'h5B, 1'b0, 1'b0);
        add_vec(75, 6'h37, 8'h4F, 1'b0, 1'b0);
        add_vec(83, 6'h2F, 8'h66, 1'b0, 1'b0);
        add_vec(91, 6'h1F, 8'h6D, 1'b0, 1'b0);
        add_vec(96, 6'h1F, 8'h6D, 1'b0, 1'b0);
        add_vec(97, 6'h3F, 8'h00, 1'b0, 1'b1);
        add_vec(99, 6'h3E, 8'hBF, 1'b0, 1'b0);
        do_reset();
        run("scan_decode", 100, 1'b0, 1'b0);

        // ---------------- disabled digits ----------------
        clear_tables();
        add_load(5, 24'hFEDCBA, 6'b000000, 6'b101010);
        add_vec(51,  6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(59,  6'h3D, 8'h7C, 1'b0, 1'b0);
        add_vec(67,  6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(75,  6'h37, 8'h5E, 1'b0, 1'b0);
        add_vec(83,  6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(91,  6'h1F, 8'h71, 1'b0, 1'b0);
        add_vec(139, 6'h1F, 8'h71, 1'b0, 1'b0);
        add_vec(145, 6'h3F, 8'h00, 1'b0, 1'b1);
        do_reset();
        run("disabled", 150, 1'b0, 1'b1);

        // ---------------- load at boundary ----------------
        clear_tables();
        add_load(20, 24'h111111, 6'b000000, 6'h3F);
        add_load(47, 24'h222222, 6'b000000, 6'h3F);
        add_vec(21,  6'h3F, 8'h00, 1'b1, 1'b0);
        add_vec(47,  6'h3F, 8'h00, 1'b1, 1'b0);
        add_vec(48,  6'h3F, 8'h00, 1'b1, 1'b0);
        add_vec(51,  6'h3E, 8'h06, 1'b1, 1'b0);
        add_vec(91,  6'h1F, 8'h06, 1'b1, 1'b0);
        add_vec(95,  6'h1F, 8'h06, 1'b1, 1'b0);
        add_vec(96,  6'h1F, 8'h06, 1'b0, 1'b0);
        add_vec(99,  6'h3E, 8'h5B, 1'b0, 1'b0);
        add_vec(139, 6'h1F, 8'h5B, 1'b0, 1'b0);
        do_reset();
        run("load_boundary", 145, 1'b0, 1'b0);

        // ---------------- reset mid-operation ----------------
        clear_tables();
        add_load(5,  24'h543210, 6'b000001, 6'h3F);
        add_load(60, 24'hABCDEF, 6'b000000, 6'h00);
        add_vec(61, 6'h3D, 8'h06, 1'b1, 1'b0);
        add_vec(75, 6'h37, 8'h4F, 1'b1, 1'b0);
        do_reset();
        run("mid_reset_pre", 76, 1'b0, 1'b0);
        // now in cycle 76, slot 3 DRIVE: reset for one cycle
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset digit_cath", 32'(digit_cath), 32'h3F);
        check("mid_reset seg", 32'(seg), 32'h00);
        check("mid_reset pending", 32'(pending), 32'd0);
        check("mid_reset frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        clear_tables();
        add_vec(0,  6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(1,  6'h3F, 8'h00, 1'b0, 1'b1);
        add_vec(49, 6'h3F, 8'h00, 1'b0, 1'b1);
        add_vec(51, 6'h3F, 8'h00, 1'b0, 1'b0);
        add_vec(91, 6'h3F, 8'h00, 1'b0, 1'b0);
        run("mid_reset_post", 100, 1'b1, 1'b0);

        // ---------------- back-to-back loads ----------------
        clear_tables();
        add_load(10, 24'h111111, 6'h3F, 6'h3F);
        add_load(11, 24'h777777, 6'h3F, 6'h3F);
        add_load(12, 24'h999999, 6'b100000, 6'h3F);
        add_vec(13, 6'h3F, 8'h00, 1'b1, 1'b0);
        add_vec(51, 6'h3E, 8'h6F, 1'b0, 1'b0);
        add_vec(67, 6'h3B, 8'h6F, 1'b0, 1'b0);
        add_vec(91, 6'h1F, 8'hEF, 1'b0, 1'b0);
        do_reset();
        run("back_to_back", 100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
